// File: rtl/rs_scheduler_if.sv
// Dispatch/issue handshake bundle between the RS bank (master) and rs_scheduler (slave).
// Entry-side signals are one bit per reservation-station entry.
interface rs_scheduler_if #(
  parameter int RS_SIZE = 8,
  parameter int IDX_W   = $clog2(RS_SIZE)
);
  logic               squash;
  logic               dispatch_valid;
  logic [RS_SIZE-1:0] entry_busy;
  logic [RS_SIZE-1:0] entry_ready;
  logic               fu_avail;
  logic [RS_SIZE-1:0] entry_wr_en;
  logic [RS_SIZE-1:0] entry_clear;
  logic               dispatch_stall;
  logic               issue_valid;
  logic [IDX_W-1:0]   issue_idx;
  logic [IDX_W:0]     rs_count;
  logic               rs_full;

  modport master (
    output squash, dispatch_valid, entry_busy, entry_ready, fu_avail,
    input  entry_wr_en, entry_clear, dispatch_stall, issue_valid, issue_idx,
           rs_count, rs_full
  );

  modport slave (
    input  squash, dispatch_valid, entry_busy, entry_ready, fu_avail,
    output entry_wr_en, entry_clear, dispatch_stall, issue_valid, issue_idx,
           rs_count, rs_full
  );
endinterface

// File: rtl/rs_scheduler.sv
// Reservation-station scheduler: lowest-free allocation, single-grant issue select, occupancy.
// Define RS_AGE_ORDER_EN for oldest-first issue via an age matrix; otherwise lowest-index wins.
module rs_scheduler #(
  parameter int RS_SIZE = 8,
  parameter int IDX_W   = $clog2(RS_SIZE)
) (
  input logic           clock,
  input logic           reset,
  rs_scheduler_if.slave rs
);

  logic [RS_SIZE-1:0] free;
  logic [RS_SIZE-1:0] alloc_oh;
  logic [RS_SIZE-1:0] cand;
  logic [RS_SIZE-1:0] pick;
  logic [RS_SIZE-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               alloc;
  logic               issue;
  logic               found_alloc;
  logic               found_grant;
  logic [IDX_W:0]     rs_count_d, rs_count_q;
  logic               rs_full_d, rs_full_q;

  always_comb begin
    free        = ~rs.entry_busy;
    alloc_oh    = '0;
    found_alloc = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (rs.dispatch_valid && free[i] && !found_alloc) begin
        alloc_oh[i] = 1'b1;
        found_alloc = 1'b1;
      end
    end
    alloc = found_alloc;
    cand  = rs.entry_ready & rs.entry_busy & {RS_SIZE{rs.fu_avail}};
  end

`ifdef RS_AGE_ORDER_EN
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age_d, age_q;
  logic [RS_SIZE-1:0]              oldest;

  // Stale rows of freed entries never matter: only busy candidates take part in the compare.
  always_comb begin
    oldest = cand;
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (j != i && cand[j] && !age_q[i][j]) begin
          oldest[i] = 1'b0;
        end
      end
    end
    pick = (|oldest) ? oldest : cand;
  end

  always_comb begin
    age_d = age_q;
    if (rs.squash) begin
      age_d = '0;
    end else begin
      for (int k = 0; k < RS_SIZE; k++) begin
        if (alloc_oh[k]) begin
          age_d[k] = '0;
          for (int i = 0; i < RS_SIZE; i++) begin
            if (i != k) begin
              age_d[i][k] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign pick = cand;
`endif

  // Final priority pick guarantees a single grant even if the age view is ambiguous.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    found_grant = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (pick[i] && !found_grant) begin
        grant[i]    = 1'b1;
        grant_idx   = IDX_W'(i);
        found_grant = 1'b1;
      end
    end
    issue = found_grant;
  end

  always_comb begin
    rs_count_d = rs_count_q;
    if (rs.squash) begin
      rs_count_d = '0;
    end else if (alloc && !issue) begin
      rs_count_d = rs_count_q + (IDX_W+1)'(1);
    end else if (!alloc && issue) begin
      rs_count_d = rs_count_q - (IDX_W+1)'(1);
    end
    rs_full_d = (rs_count_d == (IDX_W+1)'(RS_SIZE));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rs_count_q <= '0;
      rs_full_q  <= 1'b0;
    end else begin
      rs_count_q <= rs_count_d;
      rs_full_q  <= rs_full_d;
    end
  end

  assign rs.entry_wr_en    = reset ? '0 : alloc_oh;
  assign rs.entry_clear    = reset ? '0 : grant;
  assign rs.dispatch_stall = !reset && rs.dispatch_valid && (free == '0);
  assign rs.issue_valid    = !reset && issue;
  assign rs.issue_idx      = reset ? '0 : grant_idx;
  assign rs.rs_count       = rs_count_q;
  assign rs.rs_full        = rs_full_q;

`ifndef SYNTHESIS
  a_wr_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(rs.entry_wr_en));
  a_clr_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(rs.entry_clear));
  a_no_overlap: assert property (@(posedge clock) disable iff (reset)
                                 (rs.entry_wr_en & rs.entry_clear) == '0);
  a_count_match: assert property (@(posedge clock) disable iff (reset)
                                  rs_count_q == (IDX_W+1)'($countones(rs.entry_busy)));
`endif

endmodule

// File: tb/tb_rs_scheduler.sv
// Directed bench for rs_scheduler: vector table plus squash and full-drain sequences.
// Entry busy bits are modelled here from the DUT's write-enable/clear strobes.
module tb_rs_scheduler;

  logic       clock;
  logic       reset;
  logic [7:0] busy_q;
  int         checks;
  int         errors;

  typedef struct {
    logic       disp;
    logic [7:0] ready;
    logic       fu;
    logic [7:0] exp_wr;
    logic [7:0] exp_clr;
    logic       exp_stall;
    logic       exp_iv;
    logic [2:0] exp_idx;
    logic [3:0] exp_cnt;
    logic       exp_full;
  } vec_t;

  vec_t vecs[$];

  rs_scheduler_if #(.RS_SIZE(8)) rs_if ();

  rs_scheduler #(.RS_SIZE(8)) dut (
    .clock (clock),
    .reset (reset),
    .rs    (rs_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Entry bank model: busy rises after wr_en, falls after clear, flushed on reset/squash.
  always @(posedge clock) begin
    if (reset || rs_if.squash) busy_q <= '0;
    else                       busy_q <= (busy_q & ~rs_if.entry_clear) | rs_if.entry_wr_en;
  end
  assign rs_if.entry_busy = busy_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic disp, input logic [7:0] ready,
                                input logic fu, input logic sq);
    @(negedge clock);
    rs_if.dispatch_valid = disp;
    rs_if.entry_ready    = ready;
    rs_if.fu_avail       = fu;
    rs_if.squash         = sq;
    #1;
  endtask

  task automatic check_output(input string tag, input vec_t v);
    check({tag, " wr_en"}, 32'(rs_if.entry_wr_en), 32'(v.exp_wr));
    check({tag, " clear"}, 32'(rs_if.entry_clear), 32'(v.exp_clr));
    check({tag, " stall"}, 32'(rs_if.dispatch_stall), 32'(v.exp_stall));
    check({tag, " issue_valid"}, 32'(rs_if.issue_valid), 32'(v.exp_iv));
    check({tag, " issue_idx"}, 32'(rs_if.issue_idx), 32'(v.exp_idx));
    check({tag, " rs_count"}, 32'(rs_if.rs_count), 32'(v.exp_cnt));
    check({tag, " rs_full"}, 32'(rs_if.rs_full), 32'(v.exp_full));
  endtask

  function automatic void add_vec(input logic disp, input logic [7:0] ready, input logic fu,
                                  input logic [7:0] wr, input logic [7:0] clr, input logic stall,
                                  input logic iv, input logic [2:0] idx, input logic [3:0] cnt,
                                  input logic full);
    vec_t v;
    v.disp = disp;  v.ready = ready;   v.fu = fu;
    v.exp_wr = wr;  v.exp_clr = clr;   v.exp_stall = stall;
    v.exp_iv = iv;  v.exp_idx = idx;   v.exp_cnt = cnt;  v.exp_full = full;
    vecs.push_back(v);
  endfunction

  task automatic reset_dut();
    @(negedge clock);
    reset                = 1'b1;
    rs_if.dispatch_valid = 1'b1;
    rs_if.entry_ready    = 8'hFF;
    rs_if.fu_avail       = 1'b1;
    rs_if.squash         = 1'b0;
    #1;
    check("reset wr_en", 32'(rs_if.entry_wr_en), 32'h0);
    check("reset stall", 32'(rs_if.dispatch_stall), 32'h0);
    check("reset issue_valid", 32'(rs_if.issue_valid), 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset                = 1'b0;
    rs_if.dispatch_valid = 1'b0;
    rs_if.entry_ready    = 8'h00;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] drain_order [8];
    logic [7:0] b_clr, d_wr;
    logic [2:0] b_idx;
    vec_t       hv;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    rs_if.squash         = 1'b0;
    rs_if.dispatch_valid = 1'b0;
    rs_if.entry_ready    = 8'h00;
    rs_if.fu_avail       = 1'b0;

`ifdef RS_AGE_ORDER_EN
    drain_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd5};
    b_clr = 8'h04; b_idx = 3'd2; d_wr = 8'h04;
`else
    drain_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    b_clr = 8'h01; b_idx = 3'd0; d_wr = 8'h01;
`endif

    // Fill, stall when full, issue+stall at full, refill, drain with everything ready.
    for (int k = 0; k < 8; k++) add_vec(1, 8'h00, 1, 8'(1 << k), 8'h00, 0, 0, 0, 4'(k), 0);
    add_vec(1, 8'h00, 1, 8'h00, 8'h00, 1, 0, 0, 4'd8, 1);
    add_vec(1, 8'h20, 1, 8'h00, 8'h20, 1, 1, 5, 4'd8, 1);
    add_vec(1, 8'h00, 1, 8'h20, 8'h00, 0, 0, 0, 4'd7, 0);
    add_vec(0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0, 4'd8, 1);
    for (int n = 0; n < 8; n++)
      add_vec(0, 8'hFF, 1, 8'h00, 8'(1 << drain_order[n]), 0, 1, drain_order[n],
              4'(8 - n), (n == 0));
    add_vec(0, 8'hFF, 1, 8'h00, 8'h00, 0, 0, 0, 4'd0, 0);
    // Age ordering after reallocation of entry 0, then fu_avail gating and alloc+issue.
    add_vec(1, 8'h00, 1, 8'h01, 8'h00, 0, 0, 0, 4'd0, 0);
    add_vec(1, 8'h00, 1, 8'h02, 8'h00, 0, 0, 0, 4'd1, 0);
    add_vec(1, 8'h00, 1, 8'h04, 8'h00, 0, 0, 0, 4'd2, 0);
    add_vec(0, 8'h01, 1, 8'h00, 8'h01, 0, 1, 0, 4'd3, 0);
    add_vec(1, 8'h00, 1, 8'h01, 8'h00, 0, 0, 0, 4'd2, 0);
    add_vec(0, 8'h05, 1, 8'h00, b_clr, 0, 1, b_idx, 4'd3, 0);
    add_vec(1, 8'h00, 1, d_wr, 8'h00, 0, 0, 0, 4'd2, 0);
    add_vec(0, 8'h02, 0, 8'h00, 8'h00, 0, 0, 0, 4'd3, 0);
    add_vec(0, 8'h02, 1, 8'h00, 8'h02, 0, 1, 1, 4'd3, 0);
    add_vec(1, 8'h01, 1, 8'h02, 8'h01, 0, 1, 0, 4'd2, 0);
    add_vec(0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0, 4'd2, 0);

    reset_dut();
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].disp, vecs[i].ready, vecs[i].fu, 1'b0);
      check_output($sformatf("v%0d", i), vecs[i]);
    end

    // Squash with four entries held, a dispatch and a ready entry all in the same cycle.
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 8'h00, 1'b1, 1'b0);
      check($sformatf("sq fill%0d wr_en", k), 32'(rs_if.entry_wr_en), 32'(1 << k));
    end
    apply_stimulus(1'b1, 8'h01, 1'b1, 1'b1);
    check("sq pre count", 32'(rs_if.rs_count), 32'd4);
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1'b1, 8'h00, 1'b1, 1'b0);
      hv = '{disp: 1, ready: 0, fu: 1, exp_wr: 8'(1 << k), exp_clr: 0, exp_stall: 0,
             exp_iv: 0, exp_idx: 0, exp_cnt: 4'(k), exp_full: 0};
      check_output($sformatf("post-sq fill%0d", k), hv);
    end

    // In-order fill, everything ready: one grant per cycle, indices ascending.
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1'b0, 8'hFF, 1'b1, 1'b0);
      hv = '{disp: 0, ready: 8'hFF, fu: 1, exp_wr: 0, exp_clr: 8'(1 << k), exp_stall: 0,
             exp_iv: 1, exp_idx: 3'(k), exp_cnt: 4'(8 - k), exp_full: (k == 0)};
      check_output($sformatf("all-ready%0d", k), hv);
    end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check("final count", 32'(rs_if.rs_count), 32'd0);
    check("final issue_valid", 32'(rs_if.issue_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs_scheduler.md
Name: rs_scheduler

Overview:
- Controller for a bank of N reservation-station entries; sits between decode/dispatch and the issue stage.
- Per cycle, allocates one free entry for an incoming dispatch by raising that entry's write enable.
- Selects one ready entry for issue, oldest-first, and raises that entry's clear.
- Tracks relative entry age and occupancy so that a full RS stalls dispatch.

Parameters:
- RS_SIZE, 8, number of RS entries managed (power of two, at least 2)
- IDX_W, $clog2(RS_SIZE), width of entry index outputs

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- squash  in  1  synchronous flush; same effect as reset on all internal state
- dispatch_valid  in  1  decode presents an instruction to allocate this cycle
- entry_busy  in  RS_SIZE  registered busy bit from each entry
- entry_ready  in  RS_SIZE  operands-ready bit from each entry (includes CDB forwarding)
- fu_avail  in  1  issue stage can accept an instruction this cycle
- entry_wr_en  out  RS_SIZE  one-hot write enable to the allocated entry
- entry_clear  out  RS_SIZE  one-hot clear to the issued entry
- dispatch_stall  out  1  dispatch_valid asserted but no free entry
- issue_valid  out  1  an entry is issued this cycle
- issue_idx  out  IDX_W  index of the issued entry (0 when issue_valid=0)
- rs_count  out  IDX_W+1  registered occupancy count
- rs_full  out  1  rs_count==RS_SIZE

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset).
- Reset/squash values, at the next posedge:
  - age matrix cleared
  - rs_count=0, rs_full=0
  - all outputs that depend on the inputs are 0 while reset is high
- Squash has the same priority as reset. A dispatch or issue in a squash cycle is ignored for internal state.
- Allocation (combinational, same cycle):
  - free = ~entry_busy.
  - entry_wr_en = lowest-index free bit when dispatch_valid=1, else 0.
  - dispatch_stall = dispatch_valid & (free==0).
  - An entry being cleared this cycle is still busy and is not reused until the next cycle.
- Issue select (combinational, same cycle): cand = entry_ready & entry_busy, gated by fu_avail.
  - Grant the oldest cand.
  - entry_clear = one-hot grant; issue_valid = |grant; issue_idx = encoded grant.
  - With fu_avail=0: no grant, no clear.
- Issue and allocation in the same cycle never target the same entry, because one requires busy and the other requires free.
- Age matrix: RS_SIZE x RS_SIZE registered bits; age[i][j]=1 means i is older than j.
  - On allocation to k: row k is cleared to 0 and column k is set to 1 for all i≠k. This makes k the youngest.
  - On issue: no update is needed, because stale rows are masked by busy.
  - Oldest cand i: for every j≠i with cand[j], age[i][j]=1.
  - Exactly one grant, even if every entry is cand.
- Occupancy: rs_count_next = rs_count + alloc - issue (both 0/1).
  - Simultaneous alloc and issue leaves rs_count unchanged.
  - rs_count never wraps: allocation is impossible at RS_SIZE, and issue is impossible at 0.
- Latency:
  - Entry busy rises one cycle after entry_wr_en, and falls one cycle after entry_clear.
  - Earliest issue of a dispatched instruction is the cycle after allocation.
- Simulation asserts:
  - entry_wr_en and entry_clear are each $onehot0.
  - entry_wr_en & entry_clear == 0.
  - rs_count == popcount(entry_busy) one cycle after any update.

Optional Feature:
- RS_AGE_ORDER_EN
  - Defined: oldest-first select via the age matrix, as above.
  - Undefined: the age matrix is not instantiated, and issue grants the lowest-index cand (fixed priority). Allocation, occupancy and every other behaviour are unchanged.

Test Plan:
- Reset, then dispatch_valid=1 for 8 cycles with entry_busy fed back and no ready entries -> entry_wr_en = 0x01, 0x02, 0x04, ..., 0x80. rs_count reaches 8, rs_full=1. Ninth request -> dispatch_stall=1, entry_wr_en=0.
- Allocate entries in order 0,1,2 (RS_AGE_ORDER_EN), clear 0, allocate 0 again, then entries 0 and 2 ready -> issue_idx=2, entry_clear=0x04. Without the macro -> issue_idx=0.
- rs_count=8, with entry 5 ready and dispatch_valid=1 -> entry_clear=0x20 and dispatch_stall=1 in the same cycle. The next cycle entry_wr_en=0x20, and rs_count goes 8→7→8.
- With rs_count=3, ready entry present, fu_avail=0 -> issue_valid=0, entry_clear=0. Set fu_avail=1 -> grant in that same cycle.
- Fill 4 entries, then pulse squash with dispatch_valid=1 and a ready entry -> rs_count=0 the next cycle and age state cleared. A subsequent allocation goes to the lowest free index.
- All 8 entries ready simultaneously after in-order fill (RS_AGE_ORDER_EN) -> issues 0,1,...,7 on consecutive cycles, exactly one grant per cycle.
